// File: rtl/otter_alu_pkg.sv
// Shared types and helpers for the OTTER ALU and its two-client arbiter.
package otter_alu_pkg;

  localparam int unsigned DATA_W = 32;

  // Result returned by the ALU for any code outside the legal set.
  localparam logic [DATA_W-1:0] ALU_DEFAULT = 32'd42;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b1000,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SLL  = 4'b0001,
    ALU_SRA  = 4'b1101,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_LUI  = 4'b1001
  } alu_fun_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_t;

  // True when the code is one the ALU actually implements.
  function automatic bit is_legal_fun(alu_fun_t fun);
    case (fun)
      ALU_ADD, ALU_SUB, ALU_OR, ALU_AND, ALU_XOR, ALU_SRL,
      ALU_SLL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_LUI: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/otter_alu.sv
// OTTER 32-bit ALU: purely combinational, one result per function code.
module otter_alu
  import otter_alu_pkg::*;
(
  input  alu_fun_t          fun,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic [DATA_W-1:0] result
);

  // Select the operation; unknown codes fall through to the fixed default.
  always_comb begin
    // NOTE: every always_comb output gets a value before any branch, so no path can infer a latch.
    result = ALU_DEFAULT;
    case (fun)
      ALU_ADD:  result = src_a + src_b;
      ALU_SUB:  result = src_a - src_b;
      ALU_OR:   result = src_a | src_b;
      ALU_AND:  result = src_a & src_b;
      ALU_XOR:  result = src_a ^ src_b;
      ALU_SRL:  result = src_a >> src_b[4:0];
      ALU_SLL:  result = src_a << src_b[4:0];
      ALU_SRA:  result = $unsigned($signed(src_a) >>> src_b[4:0]);
      ALU_SLT:  result = {31'b0, $signed(src_a) < $signed(src_b)};
      ALU_SLTU: result = {31'b0, src_a < src_b};
      ALU_LUI:  result = src_a;
      default:  result = ALU_DEFAULT;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one OTTER ALU between two valid/ready clients: grant, execute,
// then hold the registered result until the owner accepts it.
module alu_arbiter
  import otter_alu_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [3:0]        req_fun0,
  input  logic [3:0]        req_fun1,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [DATA_W-1:0] req_b1,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_illegal,
  output logic              busy
);

  arb_state_t        state_q, state_d;
  logic              last_grant_q;
  logic              owner_q;
  logic              grant_idx;
  logic              grant_fire;
  alu_fun_t          op_fun_q;
  logic [DATA_W-1:0] op_a_q, op_b_q;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] result_q;
  logic              illegal_q;

  // Pick the winner among the currently valid requesters.
  always_comb begin
    grant_idx = 1'b0;
    case (req_valid)
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = RR_EN ? ~last_grant_q : 1'b0;
      default: grant_idx = 1'b0;
    endcase
  end

  // A grant happens only in IDLE and never while reset is held.
  assign grant_fire = (state_q == IDLE) && (|req_valid) && !RST;

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    case (state_q)
      IDLE: begin
        if (grant_fire) begin
          req_ready[grant_idx] = 1'b1;
          state_d              = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        rsp_valid[owner_q] = 1'b1;
        if (rsp_ready[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Arbitration bookkeeping: who owns the op in flight and who won last.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
    end else if (grant_fire) begin
      last_grant_q <= grant_idx;
      owner_q      <= grant_idx;
    end
  end

  // Operand capture at grant time.
  always_ff @(posedge CLK) begin
    // NOTE: operand registers carry no reset; they are always loaded at grant before anything reads them.
    if (grant_fire) begin
      op_fun_q <= alu_fun_t'(grant_idx ? req_fun1 : req_fun0);
      op_a_q   <= grant_idx ? req_a1 : req_a0;
      op_b_q   <= grant_idx ? req_b1 : req_b0;
    end
  end

  otter_alu u_alu (
    .fun    (op_fun_q),
    .src_a  (op_a_q),
    .src_b  (op_b_q),
    .result (alu_result)
  );

  // Response payload: written only in EXEC, stable through the RESP hold.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else if (state_q == EXEC) begin
      result_q  <= alu_result;
      illegal_q <= !is_legal_fun(op_fun_q);
    end
  end

  assign rsp_result  = result_q;
  assign rsp_illegal = illegal_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized
// run against a behavioural model of grant order and ALU results.
`timescale 1ns/1ps
module tb_alu_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [3:0]  req_fun0 = '0, req_fun1 = '0;
  logic [31:0] req_a0 = '0, req_a1 = '0, req_b0 = '0, req_b1 = '0;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = 2'b00;
  logic [31:0] rsp_result;
  logic        rsp_illegal;
  logic        busy;

  logic [1:0]  fp_req_valid = 2'b00;
  logic [1:0]  fp_req_ready;
  logic [1:0]  fp_rsp_valid;
  logic [31:0] fp_rsp_result;
  logic        fp_rsp_illegal;
  logic        fp_busy;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int model_last = 1;

  logic [3:0]  fun_s [2];
  logic [31:0] a_s   [2];
  logic [31:0] b_s   [2];

  alu_arbiter #(.RR_EN(1'b1)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_fun0(req_fun0), .req_fun1(req_fun1),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_illegal(rsp_illegal), .busy(busy)
  );

  alu_arbiter #(.RR_EN(1'b0)) dut_fp (
    .CLK(CLK), .RST(RST),
    .req_valid(fp_req_valid), .req_ready(fp_req_ready),
    .req_fun0(req_fun0), .req_fun1(req_fun1),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(fp_rsp_result), .rsp_illegal(fp_rsp_illegal), .busy(fp_busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_alu(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    logic [63:0] ext;
    sh = int'(b[4:0]);
    case (f)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0110: return a | b;
      4'b0111: return a & b;
      4'b0100: return a ^ b;
      4'b0101: return a >> sh;
      4'b0001: return a << sh;
      4'b1101: begin
        ext = {{32{a[31]}}, a} >> sh;
        return ext[31:0];
      end
      4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: return (a < b) ? 32'd1 : 32'd0;
      4'b1001: return a;
      default: return 32'd42;
    endcase
  endfunction

  function automatic logic ref_illegal(input logic [3:0] f);
    return !(f inside {4'b0000, 4'b1000, 4'b0110, 4'b0111, 4'b0100, 4'b0101,
                       4'b0001, 4'b1101, 4'b0010, 4'b0011, 4'b1001});
  endfunction

  function automatic int model_grant(input logic [1:0] mask, input bit rr);
    if (mask == 2'b01) return 0;
    if (mask == 2'b10) return 1;
    return rr ? (1 - model_last) : 0;
  endfunction

  function automatic logic [1:0] onehot(input int r);
    return (r == 0) ? 2'b01 : 2'b10;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic apply_payload();
    req_fun0 = fun_s[0]; req_a0 = a_s[0]; req_b0 = b_s[0];
    req_fun1 = fun_s[1]; req_a1 = a_s[1]; req_b1 = b_s[1];
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    req_valid = 2'b00; fp_req_valid = 2'b00;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    model_last = 1;
  endtask

  // Waits (bounded) for a grant; returns 2'b00 if none appears.
  task automatic wait_grant(input bit fp, output logic [1:0] seen);
    int waits;
    waits = 0;
    @(negedge CLK);
    while (((fp ? fp_req_ready : req_ready) == 2'b00) && waits < 8) begin
      @(negedge CLK);
      waits++;
    end
    seen = fp ? fp_req_ready : req_ready;
  endtask

  // One op from a single requester with the response accepted immediately.
  task automatic run_op(input int r, input logic [3:0] f, input logic [31:0] a,
                        input logic [31:0] b, input string name);
    logic [1:0]  seen;
    logic [31:0] exp_res;
    exp_res = ref_alu(f, a, b);
    @(posedge CLK); #1;
    rsp_ready = 2'b11;
    fun_s[r] = f; a_s[r] = a; b_s[r] = b;
    apply_payload();
    req_valid = onehot(r);
    wait_grant(1'b0, seen);
    total_cnt++;
    if (seen !== onehot(r)) $display("FAIL %s_grant: req_ready=%b expected %b", name, seen, onehot(r));
    else pass_cnt++;
    model_last = r;
    @(posedge CLK); #1;
    req_valid = 2'b00;
    @(negedge CLK);
    total_cnt++;
    if ({rsp_valid, busy} !== 3'b001) $display("FAIL %s_exec: rsp_valid,busy=%b expected 001", name, {rsp_valid, busy});
    else pass_cnt++;
    @(negedge CLK);
    total_cnt++;
    if ({rsp_valid, rsp_result, rsp_illegal} !== {onehot(r), exp_res, ref_illegal(f)})
      $display("FAIL %s_rsp: valid=%b result=%h illegal=%b expected valid=%b result=%h illegal=%b",
               name, rsp_valid, rsp_result, rsp_illegal, onehot(r), exp_res, ref_illegal(f));
    else pass_cnt++;
    @(posedge CLK);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      fun_s[i] = 4'b0000; a_s[i] = $urandom; b_s[i] = $urandom;
    end
    apply_payload();
    req_valid = 2'b11; fp_req_valid = 2'b11; rsp_ready = 2'b11;
    #3;
    total_cnt++;
    if ({req_ready, rsp_valid, rsp_result, rsp_illegal, busy} !== 38'd0)
      $display("FAIL reset_outputs: ready=%b valid=%b result=%h illegal=%b busy=%b expected all 0",
               req_ready, rsp_valid, rsp_result, rsp_illegal, busy);
    else pass_cnt++;
    total_cnt++;
    if ({fp_req_ready, fp_busy} !== 3'b000) $display("FAIL reset_fp: ready,busy=%b expected 000", {fp_req_ready, fp_busy});
    else pass_cnt++;
    @(posedge CLK); #1;
    total_cnt++;
    if ({req_ready, busy} !== 3'b000) $display("FAIL reset_after_edge: ready,busy=%b expected 000", {req_ready, busy});
    else pass_cnt++;
    req_valid = 2'b00; fp_req_valid = 2'b00;
    @(posedge CLK); #1;
    RST = 1'b0;
    model_last = 1;
  endtask

  task automatic test_single_add();
    run_op(0, 4'b0000, 32'd5, 32'd7, "single_add");
  endtask

  task automatic test_rr_tie();
    logic [1:0]  seen;
    logic [31:0] exp_res;
    int g;
    do_reset();
    @(posedge CLK); #1;
    rsp_ready = 2'b11;
    for (int i = 0; i < 2; i++) begin
      fun_s[i] = 4'b0000; a_s[i] = $urandom; b_s[i] = $urandom;
    end
    apply_payload();
    req_valid = 2'b11;
    for (int n = 0; n < 4; n++) begin
      wait_grant(1'b0, seen);
      g = model_grant(2'b11, 1'b1);
      total_cnt++;
      if (seen !== onehot(n % 2) || g != n % 2)
        $display("FAIL rr_order_%0d: req_ready=%b expected %b", n, seen, onehot(n % 2));
      else pass_cnt++;
      model_last = g;
      exp_res = ref_alu(fun_s[g], a_s[g], b_s[g]);
      @(posedge CLK); #1;
      a_s[g] = $urandom; b_s[g] = $urandom;
      apply_payload();
      @(negedge CLK);
      @(negedge CLK);
      total_cnt++;
      if ({rsp_valid, rsp_result} !== {onehot(g), exp_res})
        $display("FAIL rr_rsp_%0d: valid=%b result=%h expected valid=%b result=%h", n, rsp_valid, rsp_result, onehot(g), exp_res);
      else pass_cnt++;
      @(posedge CLK);
    end
    #1;
    req_valid = 2'b00;
    repeat (3) @(posedge CLK);
  endtask

  task automatic test_fixed_priority();
    logic [1:0]  seen;
    logic [31:0] exp_res;
    int g;
    do_reset();
    @(posedge CLK); #1;
    rsp_ready = 2'b11;
    fun_s[0] = 4'b0000; a_s[0] = $urandom; b_s[0] = $urandom;
    fun_s[1] = 4'b1000; a_s[1] = $urandom; b_s[1] = $urandom;
    apply_payload();
    fp_req_valid = 2'b11;
    for (int n = 0; n < 5; n++) begin
      wait_grant(1'b1, seen);
      g = (n < 4) ? 0 : 1;
      total_cnt++;
      if (seen !== onehot(g)) $display("FAIL fp_order_%0d: req_ready=%b expected %b", n, seen, onehot(g));
      else pass_cnt++;
      exp_res = ref_alu(fun_s[g], a_s[g], b_s[g]);
      @(posedge CLK); #1;
      if (n == 3) fp_req_valid = 2'b10;
      if (n == 4) fp_req_valid = 2'b00;
      @(negedge CLK);
      @(negedge CLK);
      total_cnt++;
      if ({fp_rsp_valid, fp_rsp_result, fp_rsp_illegal} !== {onehot(g), exp_res, 1'b0})
        $display("FAIL fp_rsp_%0d: valid=%b result=%h illegal=%b expected valid=%b result=%h illegal=0",
                 n, fp_rsp_valid, fp_rsp_result, fp_rsp_illegal, onehot(g), exp_res);
      else pass_cnt++;
      @(posedge CLK);
    end
    repeat (2) @(posedge CLK);
  endtask

  task automatic test_shift_slt();
    run_op(1, 4'b1101, 32'h8000_0000, 32'h0000_0024, "sra");
    run_op(0, 4'b0010, 32'hFFFF_FFFF, 32'd1, "slt");
    run_op(1, 4'b0011, 32'hFFFF_FFFF, 32'd1, "sltu");
  endtask

  task automatic test_illegal();
    run_op(0, 4'b1111, $urandom, $urandom, "illegal_f");
    run_op(1, 4'b1010, $urandom, $urandom, "illegal_a");
  endtask

  task automatic test_backpressure();
    logic [1:0]  seen;
    logic [31:0] exp0, exp1;
    @(posedge CLK); #1;
    rsp_ready = 2'b10;
    fun_s[0] = 4'b0100; a_s[0] = $urandom; b_s[0] = $urandom;
    fun_s[1] = 4'b1000; a_s[1] = $urandom; b_s[1] = $urandom;
    exp0 = ref_alu(fun_s[0], a_s[0], b_s[0]);
    exp1 = ref_alu(fun_s[1], a_s[1], b_s[1]);
    apply_payload();
    req_valid = 2'b01;
    wait_grant(1'b0, seen);
    total_cnt++;
    if (seen !== 2'b01) $display("FAIL bp_grant0: req_ready=%b expected 01", seen);
    else pass_cnt++;
    model_last = 0;
    @(posedge CLK); #1;
    req_valid = 2'b10;
    @(negedge CLK);
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      total_cnt++;
      if ({rsp_valid, rsp_result, req_ready, busy} !== {2'b01, exp0, 2'b00, 1'b1})
        $display("FAIL bp_hold_%0d: valid=%b result=%h ready=%b busy=%b expected valid=01 result=%h ready=00 busy=1",
                 c, rsp_valid, rsp_result, req_ready, busy, exp0);
      else pass_cnt++;
    end
    rsp_ready = 2'b01;
    @(posedge CLK);
    @(negedge CLK);
    total_cnt++;
    if ({req_ready, rsp_valid} !== 4'b1000) $display("FAIL bp_grant1: ready,valid=%b expected 1000", {req_ready, rsp_valid});
    else pass_cnt++;
    model_last = 1;
    rsp_ready = 2'b11;
    @(posedge CLK); #1;
    req_valid = 2'b00;
    @(negedge CLK);
    @(negedge CLK);
    total_cnt++;
    if ({rsp_valid, rsp_result} !== {2'b10, exp1})
      $display("FAIL bp_rsp1: valid=%b result=%h expected valid=10 result=%h", rsp_valid, rsp_result, exp1);
    else pass_cnt++;
    @(posedge CLK);
  endtask

  task automatic test_reset_mid_exec();
    logic [1:0] seen;
    @(posedge CLK); #1;
    rsp_ready = 2'b11;
    fun_s[0] = 4'b0110; a_s[0] = 32'h1234_0000; b_s[0] = 32'h0000_5678;
    apply_payload();
    req_valid = 2'b01;
    @(negedge CLK);
    total_cnt++;
    if (req_ready !== 2'b01) $display("FAIL rst_pre_grant: req_ready=%b expected 01", req_ready);
    else pass_cnt++;
    model_last = 0;
    @(posedge CLK); #1;
    req_valid = 2'b00;
    #2;
    RST = 1'b1;
    req_valid = 2'b11;
    #1;
    total_cnt++;
    if ({req_ready, rsp_valid, rsp_result, rsp_illegal, busy} !== 38'd0)
      $display("FAIL rst_mid_exec: ready=%b valid=%b result=%h illegal=%b busy=%b expected all 0",
               req_ready, rsp_valid, rsp_result, rsp_illegal, busy);
    else pass_cnt++;
    req_valid = 2'b00;
    model_last = 1;
    @(posedge CLK); #1;
    RST = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      total_cnt++;
      if ({rsp_valid, busy} !== 3'b000) $display("FAIL rst_no_rsp_%0d: valid,busy=%b expected 000", c, {rsp_valid, busy});
      else pass_cnt++;
    end
    @(posedge CLK); #1;
    for (int i = 0; i < 2; i++) begin
      fun_s[i] = 4'b0000; a_s[i] = $urandom; b_s[i] = $urandom;
    end
    apply_payload();
    req_valid = 2'b11;
    wait_grant(1'b0, seen);
    total_cnt++;
    if (seen !== onehot(model_grant(2'b11, 1'b1))) $display("FAIL rst_next_tie: req_ready=%b expected 01", seen);
    else pass_cnt++;
    model_last = 0;
    @(posedge CLK); #1;
    req_valid = 2'b00;
    repeat (2) @(posedge CLK);
  endtask

  task automatic test_random();
    logic [1:0]  mask, seen;
    logic [31:0] exp_res;
    logic        exp_ill;
    int g, stall;
    for (int k = 0; k < 40; k++) begin
      @(posedge CLK); #1;
      rsp_ready = 2'b00;
      mask = 2'($urandom_range(1, 3));
      for (int i = 0; i < 2; i++) begin
        fun_s[i] = 4'($urandom); a_s[i] = $urandom; b_s[i] = $urandom;
      end
      apply_payload();
      req_valid = mask;
      g = model_grant(mask, 1'b1);
      wait_grant(1'b0, seen);
      total_cnt++;
      if (seen !== onehot(g)) $display("FAIL rand_grant_%0d: req_ready=%b expected %b", k, seen, onehot(g));
      else pass_cnt++;
      model_last = g;
      exp_res = ref_alu(fun_s[g], a_s[g], b_s[g]);
      exp_ill = ref_illegal(fun_s[g]);
      @(posedge CLK); #1;
      req_valid = 2'b00;
      @(negedge CLK);
      stall = $urandom_range(0, 3);
      for (int s = 0; s <= stall; s++) begin
        @(negedge CLK);
        total_cnt++;
        if ({rsp_valid, rsp_result, rsp_illegal} !== {onehot(g), exp_res, exp_ill})
          $display("FAIL rand_rsp_%0d_%0d: valid=%b result=%h illegal=%b expected valid=%b result=%h illegal=%b",
                   k, s, rsp_valid, rsp_result, rsp_illegal, onehot(g), exp_res, exp_ill);
        else pass_cnt++;
        rsp_ready = (s == stall) ? onehot(g) : (~onehot(g) & 2'($urandom));
      end
      @(posedge CLK);
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_rr_tie();
    test_fixed_priority();
    test_shift_slt();
    test_illegal();
    test_backpressure();
    test_reset_mid_exec();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the OTTER 32-bit ALU. It shares one ALU instance between two clients, for example the main execute path and a multi-cycle helper such as a CSR or mul/div sequencer. Each client uses a valid/ready request channel and a valid/ready response channel. The block latches the operands, executes one operation at a time, holds the registered result until the owning client accepts it, and flags unsupported function codes.

## Interface
Parameters:
- RR_EN, default 1: 1 = round-robin between requesters; 0 = fixed priority, requester 0 wins.

Ports (clock and reset first):
- CLK  in  1  system clock, rising-edge.
- RST  in  1  reset, asynchronous, active-high.
- req_valid  in  2  per-requester request valid (bit i = requester i).
- req_ready  out  2  per-requester request accepted this cycle.
- req_fun0, req_fun1  in  4  ALU function code per requester.
- req_a0, req_a1  in  32  srcA per requester.
- req_b0, req_b1  in  32  srcB per requester.
- rsp_valid  out  2  response valid; at most one bit set.
- rsp_ready  in  2  per-requester response accept.
- rsp_result  out  32  registered ALU result for the owner.
- rsp_illegal  out  1  the owning request used an unsupported function code.
- busy  out  1  high whenever state is not IDLE.

## Operation
FSM states: IDLE, EXEC, RESP.

- **IDLE**
  - Grant selection:
    - If exactly one req_valid bit is set, that requester is granted.
    - If both are set and RR_EN=1, the requester other than last_grant is granted.
    - If both are set and RR_EN=0, requester 0 is granted.
  - On grant:
    - req_ready[g] = 1 (combinational from req_valid, this cycle only).
    - Latch fun, a and b into op registers.
    - owner <= g; last_grant <= g; go to EXEC.
  - No req_valid bit set: remain in IDLE.
- **EXEC**
  - The ALU is driven from the op registers.
  - result_q <= ALU result.
  - illegal_q <= 1 if fun is not one of {0000, 1000, 0110, 0111, 0100, 0101, 0001, 1101, 0010, 0011, 1001}; else 0.
  - Go to RESP.
- **RESP**
  - rsp_valid[owner] = 1; rsp_result = result_q; rsp_illegal = illegal_q.
  - When rsp_ready[owner] = 1: go to IDLE.
  - rsp_ready of the non-owner is ignored.
- req_ready is 0 in EXEC and RESP. New requests wait; req_valid must stay asserted with stable payload until accepted.
- Illegal codes still execute: the ALU default result 32'd42 is returned, with rsp_illegal = 1.
- Arithmetic is 32-bit, wrap-around, no overflow flag. Shift amount is srcB[4:0]. slt is signed; sltu is unsigned.

## Timing
- Reset values: state = IDLE; last_grant = 1 (so requester 0 wins the first tie); owner = 0; result_q = 0; illegal_q = 0.
- Outputs during reset: req_ready = 0, rsp_valid = 0, rsp_result = 0, rsp_illegal = 0, busy = 0.
- Latency: grant at edge N; EXEC during cycle N+1; rsp_valid asserted in cycle N+2.
- Maximum throughput: one op per 3 cycles, when rsp_ready is already high.
- The earliest next grant is the cycle after response acceptance. There is no IDLE bypass from RESP.
- A simultaneous request from the non-owner during RESP is held off. It is granted in the next IDLE cycle, after the owner's response is accepted.
- RST asserted in EXEC or RESP:
  - The in-flight operation is dropped and no response is issued.
  - last_grant returns to 1.
- result_q and illegal_q change only in EXEC. The response payload is stable for the whole RESP hold.

## Structure
- Shared package otter_alu_pkg:
  - alu_fun_t enum with the 11 legal codes (ADD=0000, SUB=1000, OR=0110, AND=0111, XOR=0100, SRL=0101, SLL=0001, SRA=1101, SLT=0010, SLTU=0011, LUI=1001).
  - arb_state_t enum {IDLE, EXEC, RESP}.
  - A function is_legal_fun(alu_fun_t) returning bit.
- One sub-module: the existing ALU, instantiated once, driven only from the op registers. No second ALU copy.

## Test plan
- **Single add:** req 0, fun=0000, a=5, b=7, rsp_ready held 1.
  - Expect req_ready[0] at the request cycle and rsp_valid = 2'b01 two cycles later.
  - Expect rsp_result = 12, rsp_illegal = 0.
- **Round-robin tie:** both requesters valid from reset, fun=0000.
  - Expect the grant order 0, 1, 0, 1.
  - With RR_EN=0, expect four grants to requester 0 before requester 1 is served (requester 0 deasserts after 4).
- **Arithmetic shift:** req 1, fun=1101, a=0x80000000, b=0x24 (shamt = 4).
  - Expect rsp_result = 0xF8000000.
  - Also: slt with a=0xFFFFFFFF, b=1 gives 1; sltu with the same operands gives 0.
- **Illegal code:** fun=1111.
  - Expect rsp_result = 0x0000002A and rsp_illegal = 1.
- **Response backpressure:** hold rsp_ready[0] = 0 for 5 cycles while req 1 is valid.
  - Expect rsp_valid[0] and a stable result for all 5 cycles, req_ready[1] = 0, busy = 1.
  - Req 1 is granted the cycle after acceptance.
- **Reset mid-EXEC:** assert RST in EXEC.
  - Expect all outputs 0 immediately and state IDLE, with no rsp_valid after release.
  - The next tie is won by requester 0.
